// File: rtl/display_bcd_seq_pkg.sv
// Shared definitions for the 7-segment decimal display driver.
//   - digit codes that extend BCD 0..9 with minus / blank / overflow glyphs
//   - FSM state encoding
//   - seg7_encode: code -> 7-segment pattern, bit order {g,f,e,d,c,b,a}
package display_pkg;

    localparam logic [3:0] CODE_MINUS = 4'd10;
    localparam logic [3:0] CODE_BLANK = 4'd11;
    localparam logic [3:0] CODE_OVF   = 4'd15;

    typedef enum logic [1:0] {IDLE, CONV, FIN} state_t;

    localparam logic [6:0] SEG_MINUS = 7'b100_0000;   // g
    localparam logic [6:0] SEG_OVF   = 7'b100_1001;   // a, d, g
    localparam logic [6:0] SEG_BLANK = 7'b000_0000;

    // Codes 12..14 never get generated; they fall back to blank.
    function automatic logic [6:0] seg7_encode(input logic [3:0] code, input logic active_low);
        logic [6:0] p;
        case (code)
            4'd0:    p = 7'b011_1111;
            4'd1:    p = 7'b000_0110;
            4'd2:    p = 7'b101_1011;
            4'd3:    p = 7'b100_1111;
            4'd4:    p = 7'b110_0110;
            4'd5:    p = 7'b110_1101;
            4'd6:    p = 7'b111_1101;
            4'd7:    p = 7'b000_0111;
            4'd8:    p = 7'b111_1111;
            4'd9:    p = 7'b110_1111;
            4'd10:   p = SEG_MINUS;
            4'd15:   p = SEG_OVF;
            default: p = SEG_BLANK;
        endcase
        return active_low ? ~p : p;
    endfunction

endpackage

// File: rtl/display_bcd_seq_seg7.sv
// seg7_digit: one digit decoder, display code -> 7 segments.
// Ports:
//   code  in  4  digit code (0..9, CODE_MINUS, CODE_BLANK, CODE_OVF)
//   seg   out 7  segment pattern {g,f,e,d,c,b,a}, polarity set by ACTIVE_LOW
module seg7_digit
    import display_pkg::*;
#(
    parameter int ACTIVE_LOW = 1
) (
    input  logic [3:0] code,
    output logic [6:0] seg
);

    assign seg = seg7_encode(code, ACTIVE_LOW != 0);

endmodule

// File: rtl/display_bcd_seq.sv
// display_bcd_seq: sequential binary-to-decimal 7-segment display driver.
// Converts entrada to DIGITS decimal digits by double-dabble, one shift per
// clock, then decodes the digits into the registered seg bus.
// Ports:
//   clock     in   1          rising-edge clock
//   reset     in   1          asynchronous, active-high
//   start     in   1          capture entrada and convert (only when idle)
//   entrada   in   IN_W       value to display
//   busy      out  1          conversion in progress
//   done      out  1          one-cycle pulse when seg/overflow are updated
//   overflow  out  1          last result did not fit the display
//   seg       out  7*DIGITS   seg[7*i +: 7] = digit i (0 = rightmost)
module display_bcd_seq
    import display_pkg::*;
#(
    parameter int IN_W          = 32,
    parameter int DIGITS        = 5,
    parameter int SIGNED        = 0,
    parameter int LEADING_BLANK = 1,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [IN_W-1:0]       entrada,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(IN_W + 1);

    state_t              state;
    logic [IN_W-1:0]     mag;
    logic [BW-1:0]       bcd;
    logic [BW-1:0]       bcd_adj;
    logic [CW-1:0]       cnt;
    logic                neg;
    logic                sticky;
    logic                ovf;
    int                  lead;
    logic [3:0]          code [DIGITS];
    logic [7*DIGITS-1:0] pat;

    // Add-3 correction on every nibble ahead of the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++)
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end

    // Final digit codes, valid while in FIN.
    // A negative value that fits always has a zero top nibble, so the minus
    // slot at lead+1 never falls off the left end.
    always_comb begin
        lead = 0;
        for (int i = 0; i < DIGITS; i++)
            if (bcd[4*i +: 4] != 4'd0)
                lead = i;
        ovf = sticky | (neg & (bcd[BW-1 -: 4] != 4'd0));
        for (int i = 0; i < DIGITS; i++) begin
            code[i] = bcd[4*i +: 4];
            if (ovf)
                code[i] = CODE_OVF;
            else if (LEADING_BLANK != 0 && i > lead)
                code[i] = CODE_BLANK;
            if (!ovf && neg) begin
                if ((LEADING_BLANK != 0) ? (i == lead + 1) : (i == DIGITS - 1))
                    code[i] = CODE_MINUS;
            end
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        seg7_digit #(.ACTIVE_LOW(ACTIVE_LOW)) u_digit (
            .code (code[g]),
            .seg  (pat[7*g +: 7])
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            seg      <= {DIGITS{seg7_encode(CODE_BLANK, ACTIVE_LOW != 0)}};
            mag      <= '0;
            bcd      <= '0;
            cnt      <= '0;
            neg      <= 1'b0;
            sticky   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Two's-complement negate in IN_W bits: -2^(IN_W-1)
                        // maps to 2^(IN_W-1), which is exact as unsigned.
                        if (SIGNED != 0 && entrada[IN_W-1]) begin
                            neg <= 1'b1;
                            mag <= ~entrada + IN_W'(1);
                        end else begin
                            neg <= 1'b0;
                            mag <= entrada;
                        end
                        bcd    <= '0;
                        sticky <= 1'b0;
                        cnt    <= CW'(IN_W);
                        busy   <= 1'b1;
                        state  <= CONV;
                    end
                end
                CONV: begin
                    bcd    <= {bcd_adj[BW-2:0], mag[IN_W-1]};
                    mag    <= {mag[IN_W-2:0], 1'b0};
                    sticky <= sticky | bcd_adj[BW-1];
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= FIN;
                end
                FIN: begin
                    seg      <= pat;
                    overflow <= ovf;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
